// File: rtl/protocol_pkg.sv
// Shared protocol definitions for the SPI configuration path.
// Holds the framing FSM state and error encodings, the frame header byte,
// and the synth_t layout that sets the default frame payload size.
// No ports (package).
package protocol_pkg;

   localparam logic [7:0] FRAME_HEADER = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_CHECK,
      ST_WAIT_TICK,
      ST_DRAIN
   } cfg_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_BAD_HDR = 2'd1,
      ERR_BAD_SUM = 2'd2,
      ERR_SHORT   = 2'd3
   } cfg_err_e;

   // Active synth configuration; byte 0 of a frame lands in the MSB byte.
   typedef struct packed {
      logic [15:0] osc_freq;
      logic [7:0]  waveform;
      logic [7:0]  attack;
      logic [7:0]  decay;
      logic [7:0]  sustain;
      logic [7:0]  release_t;
      logic [7:0]  volume;
   } synth_t;

endpackage

// File: rtl/config_frame_controller.sv
// Framing and commit controller between the SPI slave byte stream and the
// synth configuration shadow buffer.
//
// A frame is: header byte, FRAME_BYTES payload bytes, one checksum byte
// chosen so that payload + checksum == 0 mod 2^WIDTH. Payload bytes are
// streamed into the shadow buffer as they arrive; the copy to the active
// config (commit) is only requested on a sample_tick after a fully valid
// frame, so a bad or truncated frame never becomes active.
//
// Ports:
//   clk         system clock
//   rstn        asynchronous active-low reset
//   cs_n        SPI chip select (synchronised), low = frame in progress
//   byte_in     received byte
//   byte_valid  one-cycle strobe qualifying byte_in
//   sample_tick one-cycle strobe at each audio sample boundary
//   wr_en       shadow buffer write strobe
//   wr_addr     shadow byte index, 0 = first payload byte
//   wr_data     shadow write data
//   commit      one-cycle pulse: copy shadow to active config
//   busy        controller not idle
//   err_code    last error (NONE, BAD_HDR, BAD_SUM, SHORT)
//   err_count   saturating count of rejected frames
module config_frame_controller
   import protocol_pkg::*;
#(
   parameter int                WIDTH        = 8,
   parameter int                FRAME_BYTES  = $bits(synth_t) / WIDTH,
   parameter logic [WIDTH-1:0]  FRAME_HEADER = protocol_pkg::FRAME_HEADER,
   localparam int               ADDR_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1,
   localparam int               CNT_W        = $clog2(FRAME_BYTES + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cs_n,
   input  logic [WIDTH-1:0]  byte_in,
   input  logic              byte_valid,
   input  logic              sample_tick,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic              commit,
   output logic              busy,
   output logic [1:0]        err_code,
   output logic [7:0]        err_count
);

   cfg_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  sum;

   // Checksum accumulation wraps modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] sum_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      return a + b;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         sum       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         commit    <= 1'b0;
         busy      <= 1'b0;
         err_code  <= ERR_NONE;
         err_count <= '0;
      end else begin
         wr_en  <= 1'b0;
         commit <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!cs_n) begin
                  state <= ST_HDR;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  sum   <= '0;
               end
            end

            ST_HDR: begin
               if (cs_n) begin
                  // Deselected before any byte: not an error.
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (byte_valid) begin
                  if (byte_in == FRAME_HEADER) begin
                     state <= ST_PAYLOAD;
                  end else begin
                     state     <= ST_DRAIN;
                     err_code  <= ERR_BAD_HDR;
                     err_count <= sat_inc(err_count);
                  end
               end
            end

            ST_PAYLOAD: begin
               // cs_n rising wins over a same-cycle byte: the byte is dropped.
               if (cs_n) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  err_code  <= ERR_SHORT;
                  err_count <= sat_inc(err_count);
               end else if (byte_valid) begin
                  wr_en   <= 1'b1;
                  wr_addr <= ADDR_W'(cnt);
                  wr_data <= byte_in;
                  cnt     <= cnt + 1'b1;
                  sum     <= sum_add(sum, byte_in);
                  if (cnt == CNT_W'(FRAME_BYTES - 1))
                     state <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (cs_n) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  err_code  <= ERR_SHORT;
                  err_count <= sat_inc(err_count);
               end else if (byte_valid) begin
                  if (sum_add(sum, byte_in) == '0) begin
                     state <= ST_WAIT_TICK;
                  end else begin
                     state     <= ST_DRAIN;
                     err_code  <= ERR_BAD_SUM;
                     err_count <= sat_inc(err_count);
                  end
               end
            end

            ST_WAIT_TICK: begin
               // A validated frame is committed even if cs_n has already risen.
               if (sample_tick) begin
                  commit   <= 1'b1;
                  err_code <= ERR_NONE;
                  if (cs_n) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               if (cs_n) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_frame_controller.sv
// Self-checking bench for config_frame_controller with FRAME_BYTES = 4.
// Frames are 6 bytes: header, 4 payload bytes, checksum.
module tb_config_frame_controller;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       cs_n = 1'b1;
   logic [7:0] byte_in = 8'h00;
   logic       byte_valid = 1'b0;
   logic       sample_tick = 1'b0;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       commit;
   logic       busy;
   logic [1:0] err_code;
   logic [7:0] err_count;

   int checks = 0;
   int errors = 0;

   config_frame_controller #(.WIDTH(8), .FRAME_BYTES(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cs_n       (cs_n),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .sample_tick(sample_tick),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .commit     (commit),
      .busy       (busy),
      .err_code   (err_code),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // Write / commit monitor, sampled on the inactive edge.
   int         wr_total = 0;
   int         commit_total = 0;
   logic [1:0] log_addr [256];
   logic [7:0] log_data [256];

   always @(negedge clk) begin
      if (wr_en) begin
         log_addr[wr_total & 255] <= wr_addr;
         log_data[wr_total & 255] <= wr_data;
         wr_total <= wr_total + 1;
      end
      if (commit) commit_total <= commit_total + 1;
   end

   typedef struct {
      logic [47:0] frame;
      int          exp_wr;
      logic        exp_commit;
      logic [1:0]  exp_err;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_in    = b;
      cyc();
      byte_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [47:0] f, input int nbytes);
      for (int k = 0; k < nbytes; k++) send_byte(f[47-8*k -: 8]);
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      cs_n = 1'b1;
      cyc(2);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_commit", 32'(commit), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err_code", 32'(err_code), 0);
      chk("rst_err_count", 32'(err_count), 0);
      rstn = 1'b1;
      cyc();
   endtask

   initial begin
      int wr_base, cm_base;

      vecs[0] = '{48'hA5_01_02_03_04_F6, 4, 1'b1, 2'd0, 8'd0};
      vecs[1] = '{48'h5A_01_02_03_04_F6, 0, 1'b0, 2'd1, 8'd1};
      vecs[2] = '{48'hA5_01_02_03_04_F5, 4, 1'b0, 2'd2, 8'd1};
      vecs[3] = '{48'hA5_10_20_30_40_60, 4, 1'b1, 2'd0, 8'd0};
      vecs[4] = '{48'hA5_FF_FF_FF_FF_04, 4, 1'b1, 2'd0, 8'd0};
      vecs[5] = '{48'hA5_00_00_00_00_00, 4, 1'b1, 2'd0, 8'd0};

      cyc(2);

      // Table-driven whole frames, each from a fresh reset.
      for (int v = 0; v < 6; v++) begin
         do_reset();
         wr_base = wr_total;
         cm_base = commit_total;
         cs_n = 1'b0;
         cyc();
         send_frame(vecs[v].frame, 6);
         cyc(5);
         tick();
         chk($sformatf("v%0d_commit_timing", v), 32'(commit), 32'(vecs[v].exp_commit));
         cyc(3);
         chk($sformatf("v%0d_writes", v), 32'(wr_total - wr_base), 32'(vecs[v].exp_wr));
         chk($sformatf("v%0d_commits", v), 32'(commit_total - cm_base), 32'(vecs[v].exp_commit));
         chk($sformatf("v%0d_err_code", v), 32'(err_code), 32'(vecs[v].exp_err));
         chk($sformatf("v%0d_err_count", v), 32'(err_count), 32'(vecs[v].exp_cnt));
         chk($sformatf("v%0d_busy_drain", v), 32'(busy), 1);
         for (int i = 0; i < vecs[v].exp_wr; i++) begin
            chk($sformatf("v%0d_addr%0d", v, i), 32'(log_addr[(wr_base + i) & 255]), 32'(i));
            chk($sformatf("v%0d_data%0d", v, i), 32'(log_data[(wr_base + i) & 255]),
                32'(vecs[v].frame[39-8*i -: 8]));
         end
         cs_n = 1'b1;
         cyc(2);
         chk($sformatf("v%0d_busy_idle", v), 32'(busy), 0);
      end

      // Short frame, then a good frame clears err_code.
      do_reset();
      cm_base = commit_total;
      cs_n = 1'b0;
      cyc();
      send_frame(48'hA5_01_02_00_00_00, 3);
      cs_n = 1'b1;
      cyc();
      chk("short_err_code", 32'(err_code), 3);
      chk("short_err_count", 32'(err_count), 1);
      chk("short_busy", 32'(busy), 0);
      cs_n = 1'b0;
      cyc();
      send_frame(48'hA5_01_02_03_04_F6, 6);
      cyc(2);
      tick();
      chk("short_then_good_commit", 32'(commit), 1);
      chk("short_then_good_err_code", 32'(err_code), 0);
      chk("short_then_good_err_count", 32'(err_count), 1);
      cs_n = 1'b1;
      cyc(2);
      chk("short_commits", 32'(commit_total - cm_base), 1);

      // Short inside CHECK: byte with cs_n rising is dropped.
      do_reset();
      cs_n = 1'b0;
      cyc();
      send_frame(48'hA5_01_02_03_04_00, 5);
      cs_n = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'hF6;
      cyc();
      byte_valid = 1'b0;
      chk("short_check_err_code", 32'(err_code), 3);
      chk("short_check_busy", 32'(busy), 0);

      // Tick coincident with checksum byte, then cs_n rises before the next tick.
      do_reset();
      cm_base = commit_total;
      cs_n = 1'b0;
      cyc();
      send_frame(48'hA5_01_02_03_04_00, 5);
      byte_valid  = 1'b1;
      byte_in     = 8'hF6;
      sample_tick = 1'b1;
      cyc();
      byte_valid  = 1'b0;
      sample_tick = 1'b0;
      chk("coinc_no_commit", 32'(commit), 0);
      cyc(2);
      cs_n = 1'b1;
      cyc(2);
      chk("coinc_still_busy", 32'(busy), 1);
      chk("coinc_commits_before", 32'(commit_total - cm_base), 0);
      tick();
      chk("coinc_commit", 32'(commit), 1);
      chk("coinc_idle_after", 32'(busy), 0);
      cyc();
      chk("coinc_commit_pulse", 32'(commit), 0);
      chk("coinc_commits_after", 32'(commit_total - cm_base), 1);

      // Async reset mid-payload.
      do_reset();
      cm_base = commit_total;
      cs_n = 1'b0;
      cyc();
      send_frame(48'hA5_01_02_00_00_00, 3);
      chk("pre_rst_wr_data", 32'(wr_data), 32'h02);
      rstn = 1'b0;
      #1;
      chk("arst_wr_en", 32'(wr_en), 0);
      chk("arst_wr_addr", 32'(wr_addr), 0);
      chk("arst_wr_data", 32'(wr_data), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_commit", 32'(commit), 0);
      cyc();
      rstn = 1'b1;
      cs_n = 1'b1;
      cyc(3);
      tick();
      cyc();
      chk("arst_no_commit", 32'(commit_total - cm_base), 0);

      // 260 bad headers saturate err_count.
      do_reset();
      for (int n = 0; n < 260; n++) begin
         cs_n = 1'b0;
         cyc();
         send_byte(8'h5A);
         cs_n = 1'b1;
         cyc();
         if (n == 99) chk("sat_count_100", 32'(err_count), 100);
      end
      chk("sat_count_255", 32'(err_count), 255);
      chk("sat_err_code", 32'(err_code), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
